// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding.
package serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// 1-bit full adder cell; the only arithmetic in the serial adder datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first, one bit per clock,
// with start/busy/done handshake and result held until the next accepted start.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic             fa_s;
   logic             fa_c;

   fa_cell u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_s),
      .cout (fa_c)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0].
   always_comb begin
      sum_d            = sum_q >> 1;
      sum_d[WIDTH-1]   = fa_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               carry_q <= fa_c;
               sum_q   <= sum_d;
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  cout_q  <= fa_c;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
